// File: rtl/avalon_st_dc_256to64.sv
// Avalon-ST width down-converter: each wide beat is split into RATIO narrow beats,
// first symbol in the MSBs, with SOP/EOP/empty carried onto the narrow stream.
// Optional macro AVST_DC_PROTO_CHECK_EN builds an in-packet tracker driving a sticky err_o;
// without it err_o is tied low.
module avalon_st_dc_256to64 #(
  parameter int unsigned IN_BYTES  = 32,
  parameter int unsigned OUT_BYTES = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [8*IN_BYTES-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_startofpacket_i,
  input  logic                          in_endofpacket_i,
  input  logic [$clog2(IN_BYTES)-1:0]   in_empty_i,
  output logic [8*OUT_BYTES-1:0]        out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_startofpacket_o,
  output logic                          out_endofpacket_o,
  output logic [$clog2(OUT_BYTES)-1:0]  out_empty_o,
  output logic                          err_o
);

  localparam int unsigned Ratio     = IN_BYTES / OUT_BYTES;
  localparam int unsigned InW       = 8 * IN_BYTES;
  localparam int unsigned OutW      = 8 * OUT_BYTES;
  localparam int unsigned InEmptyW  = $clog2(IN_BYTES);
  localparam int unsigned OutEmptyW = $clog2(OUT_BYTES);
  localparam int unsigned IdxW      = $clog2(Ratio);

  typedef enum logic [0:0] {StEmpty, StSend} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [IdxW-1:0]      lst_q, lst_d;
  logic [InW-1:0]       buf_data_q, buf_data_d;
  logic                 buf_sop_q, buf_sop_d;
  logic                 buf_eop_q, buf_eop_d;
  logic [OutEmptyW-1:0] buf_empty_q, buf_empty_d;

  logic [OutW-1:0]      out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [OutEmptyW-1:0] out_empty_q, out_empty_d;

  logic                 out_fire;
  logic                 last_word;
  logic                 accept;
  logic [IdxW-1:0]      lst_in;
  logic [InW-1:0]       word_sh;

  // Handshake decode; in_ready depends on out_ready so a new beat loads as the last word leaves.
  always_comb begin
    out_fire   = out_valid_q & out_ready_i;
    last_word  = (idx_q == lst_q);
    in_ready_o = ~rst_i & ((state_q == StEmpty) | (out_fire & last_word));
    accept     = in_valid_i & in_ready_o;
    // (IN_BYTES-1-empty)/OUT_BYTES is the upper bits of ~empty for power-of-two sizes.
    lst_in     = in_endofpacket_i ? ~in_empty_i[InEmptyW-1:OutEmptyW] : {IdxW{1'b1}};
  end

  // Next-state for holding register and index, then the registered output word from it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lst_d       = lst_q;
    buf_data_d  = buf_data_q;
    buf_sop_d   = buf_sop_q;
    buf_eop_d   = buf_eop_q;
    buf_empty_d = buf_empty_q;

    if (accept) begin
      state_d     = StSend;
      idx_d       = '0;
      lst_d       = lst_in;
      buf_data_d  = in_data_i;
      buf_sop_d   = in_startofpacket_i;
      buf_eop_d   = in_endofpacket_i;
      buf_empty_d = in_empty_i[OutEmptyW-1:0];
    end else if (out_fire) begin
      if (last_word) begin
        state_d = StEmpty;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    word_sh     = buf_data_d << (OutW * idx_d);
    out_valid_d = (state_d == StSend);
    out_data_d  = out_valid_d ? word_sh[InW-1 -: OutW] : '0;
    out_sop_d   = out_valid_d & buf_sop_d & (idx_d == '0);
    out_eop_d   = out_valid_d & buf_eop_d & (idx_d == lst_d);
    out_empty_d = out_eop_d ? buf_empty_d : '0;
  end

  // State and output registers; reset discards any held beat at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      idx_q       <= '0;
      lst_q       <= '0;
      buf_data_q  <= '0;
      buf_sop_q   <= 1'b0;
      buf_eop_q   <= 1'b0;
      buf_empty_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lst_q       <= lst_d;
      buf_data_q  <= buf_data_d;
      buf_sop_q   <= buf_sop_d;
      buf_eop_q   <= buf_eop_d;
      buf_empty_q <= buf_empty_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
    end
  end

  assign out_data_o          = out_data_q;
  assign out_valid_o         = out_valid_q;
  assign out_startofpacket_o = out_sop_q;
  assign out_endofpacket_o   = out_eop_q;
  assign out_empty_o         = out_empty_q;

`ifdef AVST_DC_PROTO_CHECK_EN
  logic in_pkt_q, in_pkt_d;
  logic err_q, err_d;

  // Track packet framing on accepted beats and latch any violation until reset.
  always_comb begin
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    if (accept) begin
      if ((in_startofpacket_i & in_pkt_q) | (~in_startofpacket_i & ~in_pkt_q) |
          ((in_empty_i != '0) & ~in_endofpacket_i)) begin
        err_d = 1'b1;
      end
      if (in_endofpacket_i) begin
        in_pkt_d = 1'b0;
      end else if (in_startofpacket_i) begin
        in_pkt_d = 1'b1;
      end
    end
  end

  // Tracker and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_st_dc_256to64.sv
// Directed bench for avalon_st_dc_256to64: framing, empty handling, back-to-back
// streaming, backpressure, mid-packet reset and the optional protocol error flag.
module tb_avalon_st_dc_256to64;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_sop;
  logic         in_eop;
  logic [4:0]   in_empty;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sop;
  logic         out_eop;
  logic [2:0]   out_empty;
  logic         err;

  int checks = 0;
  int errors = 0;

`ifdef AVST_DC_PROTO_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  always #5 clk = ~clk;

  avalon_st_dc_256to64 dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .in_data_i           (in_data),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_startofpacket_i  (in_sop),
    .in_endofpacket_i    (in_eop),
    .in_empty_i          (in_empty),
    .out_data_o          (out_data),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_startofpacket_o (out_sop),
    .out_endofpacket_o   (out_eop),
    .out_empty_o         (out_empty),
    .err_o               (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compares {valid, sop, eop, empty, data} as one word.
  task automatic check_word(input string tag, input logic [63:0] d, input logic sop,
                            input logic eop, input logic [2:0] emp);
    check(tag, {58'b0, out_valid, out_sop, out_eop, out_empty, out_data},
          {58'b0, 1'b1, sop, eop, emp, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [255:0] d, input logic sop, input logic eop,
                       input logic [4:0] emp);
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_empty = emp;
    in_valid = 1'b1;
  endtask

  function automatic logic [63:0] word_of(input logic [255:0] d, input int w);
    return d[255-64*w -: 64];
  endfunction

  logic [255:0] d1;
  logic [255:0] beats [3];
  logic [15:0]  pat;
  int           k;
  int           cyc;

  initial begin
    d1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    beats[0] = 256'hfedcba9876543210_0123456789abcdef_a5a5a5a5a5a5a5a5_5a5a5a5a5a5a5a5a;
    beats[1] = ~d1;
    beats[2] = d1 ^ 256'h1;
    pat = 16'b1101_0010_1100_1001;

    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_outputs", {58'b0, out_valid, out_sop, out_eop, out_empty, out_data}, '0);
    check("rst_in_ready", {127'b0, in_ready}, 128'd0);
    check("rst_err", {127'b0, err}, 128'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {127'b0, in_ready}, 128'd1);

    // Single SOP+EOP beat, full
    drive(d1, 1'b1, 1'b1, 5'd0);
    step();
    in_valid = 1'b0;
    check_word("t1_w0", 64'h0001020304050607, 1'b1, 1'b0, 3'd0);
    check("t1_rdy0", {127'b0, in_ready}, 128'd0);
    step();
    check_word("t1_w1", 64'h08090a0b0c0d0e0f, 1'b0, 1'b0, 3'd0);
    step();
    check_word("t1_w2", 64'h1011121314151617, 1'b0, 1'b0, 3'd0);
    step();
    check_word("t1_w3", 64'h18191a1b1c1d1e1f, 1'b0, 1'b1, 3'd0);
    check("t1_rdy3", {127'b0, in_ready}, 128'd1);
    step();
    check("t1_idle", {127'b0, out_valid}, 128'd0);

    // EOP beat with empty 13: three words, last has empty 5
    drive(d1, 1'b1, 1'b1, 5'd13);
    step();
    in_valid = 1'b0;
    check_word("t2_w0", 64'h0001020304050607, 1'b1, 1'b0, 3'd0);
    step();
    check_word("t2_w1", 64'h08090a0b0c0d0e0f, 1'b0, 1'b0, 3'd0);
    step();
    check_word("t2_w2", 64'h1011121314151617, 1'b0, 1'b1, 3'd5);
    check("t2_rdy2", {127'b0, in_ready}, 128'd1);
    step();
    check("t2_idle", {127'b0, out_valid}, 128'd0);

    // EOP beat with empty 24: one word, empty 0
    drive(d1, 1'b1, 1'b1, 5'd24);
    step();
    in_valid = 1'b0;
    check_word("t2b_w0", 64'h0001020304050607, 1'b1, 1'b1, 3'd0);
    step();
    check("t2b_idle", {127'b0, out_valid}, 128'd0);

    // Three-beat packet streamed back to back
    drive(beats[0], 1'b1, 1'b0, 5'd0);
    step();
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (w == 0) begin
          if (b < 2) drive(beats[b+1], 1'b0, (b == 1), 5'd0);
          else in_valid = 1'b0;
        end
        check_word($sformatf("t3_b%0d_w%0d", b, w), word_of(beats[b], w),
                   (b == 0 && w == 0), (b == 2 && w == 3), 3'd0);
        check($sformatf("t3_rdy_b%0d_w%0d", b, w), {127'b0, in_ready}, {127'b0, (w == 3)});
        step();
      end
    end
    check("t3_idle", {127'b0, out_valid}, 128'd0);

    // Backpressure: data must hold through stalls, order preserved
    out_ready = 1'b0;
    drive(beats[0], 1'b1, 1'b1, 5'd0);
    step();
    in_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      check_word($sformatf("t4_c%0d_k%0d", cyc, k), word_of(beats[0], k),
                 (k == 0), (k == 3), 3'd0);
      out_ready = pat[cyc % 16];
      step();
      if (out_ready) k++;
      cyc++;
    end
    check("t4_all_words", 128'(k), 128'd4);
    check("t4_idle", {127'b0, out_valid}, 128'd0);
    out_ready = 1'b1;

    // Reset while idx==2 drops the held beat immediately
    drive(d1, 1'b1, 1'b0, 5'd0);
    step();
    in_valid = 1'b0;
    check_word("t5_w0", word_of(d1, 0), 1'b1, 1'b0, 3'd0);
    step();
    check_word("t5_w1", word_of(d1, 1), 1'b0, 1'b0, 3'd0);
    step();
    check_word("t5_w2", word_of(d1, 2), 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    #1;
    check("t5_async_valid", {127'b0, out_valid}, 128'd0);
    check("t5_async_rdy", {127'b0, in_ready}, 128'd0);
    step();
    rst = 1'b0;
    #1;
    check("t5_rel_rdy", {127'b0, in_ready}, 128'd1);
    check("t5_rel_valid", {127'b0, out_valid}, 128'd0);
    drive(beats[1], 1'b1, 1'b1, 5'd0);
    step();
    in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check_word($sformatf("t5_new_w%0d", w), word_of(beats[1], w), (w == 0), (w == 3), 3'd0);
      step();
    end
    check("t5_err_clear", {127'b0, err}, 128'd0);

    // Non-EOP beat carrying nonzero empty
    drive(d1, 1'b1, 1'b0, 5'd4);
    #1;
    check("t6_err_before", {127'b0, err}, 128'd0);
    step();
    in_valid = 1'b0;
    check("t6_err_set", {127'b0, err}, {127'b0, ErrExp});
    for (int w = 0; w < 4; w++) begin
      check_word($sformatf("t6_w%0d", w), word_of(d1, w), (w == 0), 1'b0, 3'd0);
      step();
    end
    check("t6_err_held", {127'b0, err}, {127'b0, ErrExp});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_st_dc_256to64.md
# avalon_st_dc_256to64

Avalon-ST width down-converter that sits directly downstream of the 256-bit Avalon-ST source interface and converts each 256-bit beat into a sequence of 64-bit beats on a narrower Avalon-ST source port. It preserves packet framing (`startofpacket`, `endofpacket`, `empty`) and applies ready/valid backpressure in both directions. It holds one wide beat, supports back-to-back beats with no bubble, and is the standard entry point from the wide verification stream into 64-bit datapaths.

## Interface
- `IN_BYTES`, 32: input symbols (bytes) per beat; must be a power of two and a multiple of `OUT_BYTES`.
- `OUT_BYTES`, 8: output bytes per beat; must be a power of two. `RATIO = IN_BYTES/OUT_BYTES` (4).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 256 (`8*IN_BYTES`): wide beat. First symbol is in the MSBs, bits [255:248].
- `in_valid` input 1: wide beat valid.
- `in_ready` output 1: block accepts the wide beat.
- `in_startofpacket` input 1: first beat of a packet.
- `in_endofpacket` input 1: last beat of a packet.
- `in_empty` input 5 (`log2(IN_BYTES)`): unused bytes at the LSB end. Meaningful only with `in_endofpacket`.
- `out_data` output 64: narrow beat. First symbol is in the MSBs.
- `out_valid` output 1: narrow beat valid.
- `out_ready` input 1: downstream accepts the narrow beat.
- `out_startofpacket` output 1: first narrow beat of a packet.
- `out_endofpacket` output 1: last narrow beat of a packet.
- `out_empty` output 3 (`log2(OUT_BYTES)`): unused bytes on the last narrow beat. 0 on every other beat.
- `err` output 1: sticky protocol error flag. See Configuration.

## Operation
- Holding register with fields `buf_data`, `buf_sop`, `buf_eop`, `buf_empty`, plus an index `idx` (0..RATIO-1) and a limit `lst`.
- Two states:
  - EMPTY: no beat held.
  - SEND: beat held, narrow words being emitted.
- A wide beat is accepted when `in_valid & in_ready`. On acceptance:
  - The beat is loaded into the holding register.
  - `idx` is set to 0.
  - `lst` is `(IN_BYTES-1-in_empty)/OUT_BYTES` if `in_endofpacket`, else `RATIO-1`.
  - The state goes to SEND.
- In SEND:
  - `out_data` = `buf_data[255-64*idx -: 64]`.
  - `out_startofpacket` = `buf_sop & (idx==0)`.
  - `out_endofpacket` = `buf_eop & (idx==lst)`.
  - `out_empty` = `buf_empty[2:0]` when `out_endofpacket`, else 0.
- On each `out_valid & out_ready` with `idx != lst`, `idx` increments.
- When `idx == lst` is transferred, the word is the final word of the beat:
  - If a new wide beat is accepted in the same cycle, it is loaded and the state stays SEND.
  - Otherwise the state goes to EMPTY.
- `in_ready` = `(state==EMPTY) | (out_valid & out_ready & idx==lst)`. This is combinational from `out_ready`. No combinational path exists from `in_valid` to `out_*`.
- Example: `in_empty` = 13 with EOP gives 19 valid bytes. `lst` = 2, and the third word has `out_empty` = 5.
- Non-EOP beats always emit all `RATIO` words; `in_empty` is ignored.

## Timing
- All outputs are registered except `in_ready`.
- Reset values: `out_valid`=0, `out_startofpacket`=0, `out_endofpacket`=0, `out_empty`=0, `out_data`=0, `err`=0, state=EMPTY, `idx`=0.
- While `rst` is high, `in_ready`=0.
- Latency: a wide beat accepted at edge N presents its first narrow word with `out_valid`=1 after edge N.
- Throughput: with `out_ready` held at 1, a full wide beat takes exactly `RATIO` cycles, and consecutive beats are emitted with no idle cycle.
- Once `out_valid` is asserted, `out_*` stays stable until the word is accepted.
- If `rst` asserts mid-packet, the held beat is discarded immediately (asynchronously). After release the block is in EMPTY and the in-packet tracker is cleared.

## Configuration
- Macro `AVST_DC_PROTO_CHECK_EN`.
- When defined, an in-packet tracker (set by an accepted SOP beat, cleared by an accepted EOP beat) drives `err`. `err` is set and held until reset on any accepted beat that meets one of these conditions:
  - SOP while in-packet.
  - Non-SOP while not in-packet.
  - `in_empty != 0` without `in_endofpacket`.
- When the macro is undefined, `err` is tied to 0 and no tracker logic is built. Datapath behaviour is identical in both cases.

## Test plan
- Single SOP+EOP beat, `in_empty`=0, data 0x00..1F bytes, `out_ready`=1 → four words 0x0001..07, 0x0809..0F, 0x1011..17, 0x1819..1F. SOP on word 0, EOP on word 3, `out_empty`=0.
- EOP beat with `in_empty`=13 → three words, EOP on word 2, `out_empty`=5. `in_empty`=24 → one word, `out_empty`=0.
- 3-beat packet streamed with `out_ready`=1 → 12 contiguous words with no gap, and `in_ready` pulses in the cycle of words 3 and 7.
- `out_ready` toggling 1,0,0,1 randomly → `out_data` stable while stalled, no word lost or duplicated, order preserved.
- Assert `rst` while `idx`=2 → `out_valid` drops immediately. After release, a new packet emits correctly from word 0.
- With `AVST_DC_PROTO_CHECK_EN`, send a non-EOP beat with `in_empty`=4 → `err`=1 after the acceptance edge and held. Without the macro → `err` stays 0.
